// File: rtl/f_div_sqrt_unit.sv
// Multi-cycle IEEE-754 single-precision divide / square-root unit.
// Radix-2 restoring datapath, round-to-nearest-even, denormals flushed to signed zero.
module f_div_sqrt_unit #(
  parameter int          ITER_BITS = 26,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        OP,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic [4:0]  FFLAGS,
  output logic [2:0]  STATE_DBG
);

  // Handshake: START is taken only while BUSY=0; DONE pulses for one cycle with BUSY=1,
  // and RESULT/FFLAGS stay stable from DONE until the next accepted START.

  localparam int QW = ITER_BITS;
  localparam int RW = QW + 4;
  localparam int CW = $clog2(ITER_BITS);
  localparam logic [QW-1:0] LOW_MASK = {QW{1'b1}} >> 25;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ITER   = 3'd2,
    S_ROUND  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [QW-1:0]      quo_q, quo_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [2*QW-1:0]    rad_q, rad_d;
  logic [23:0]        dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         fflags_q, fflags_d;

  // Operand classification
  logic        s1, s2;
  logic [7:0]  e1, e2;
  logic [22:0] f1, f2;
  logic        zero1, zero2, inf1, inf2, nan1, nan2, snan1, snan2;
  logic [23:0] m1, m2;
  logic signed [9:0] ue1;

  always_comb begin
    s1 = a_q[31]; e1 = a_q[30:23]; f1 = a_q[22:0];
    s2 = b_q[31]; e2 = b_q[30:23]; f2 = b_q[22:0];
    zero1 = (e1 == 8'd0);
    zero2 = (e2 == 8'd0);
    inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
    inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
    nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
    nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
    snan1 = nan1 && !f1[22];
    snan2 = nan2 && !f2[22];
    m1 = {1'b1, f1};
    m2 = {1'b1, f2};
    ue1 = signed'({2'b00, e1}) - 10'sd127;
  end

  // Special-case results
  logic        spec_hit;
  logic [31:0] spec_res;
  logic [4:0]  spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = 32'd0;
    spec_flags = 5'd0;
    if (!op_q) begin
      if (nan1 || nan2) begin
        spec_res   = CANON_NAN;
        spec_flags = {snan1 | snan2, 4'b0000};
      end else if ((zero1 && zero2) || (inf1 && inf2)) begin
        spec_res   = CANON_NAN;
        spec_flags = 5'b10000;
      end else if (inf1) begin
        spec_res = {s1 ^ s2, 8'hFF, 23'd0};
      end else if (zero2) begin
        spec_res   = {s1 ^ s2, 8'hFF, 23'd0};
        spec_flags = 5'b01000;
      end else if (zero1 || inf2) begin
        spec_res = {s1 ^ s2, 31'd0};
      end else begin
        spec_hit = 1'b0;
      end
    end else begin
      if (nan1) begin
        spec_res   = CANON_NAN;
        spec_flags = {snan1, 4'b0000};
      end else if (zero1) begin
        spec_res = {s1, 31'd0};
      end else if (s1) begin
        spec_res   = CANON_NAN;
        spec_flags = 5'b10000;
      end else if (inf1) begin
        spec_res = {1'b0, 8'hFF, 23'd0};
      end else begin
        spec_hit = 1'b0;
      end
    end
  end

  // Iteration step: one quotient bit (div) or one root bit (sqrt)
  logic [RW-1:0]   div_cmp, rem_sh, trial, step_rem;
  logic            step_bit;

  always_comb begin
    div_cmp  = {{(RW-24){1'b0}}, dvs_q};
    rem_sh   = {rem_q[RW-3:0], rad_q[2*QW-1 -: 2]};
    trial    = {2'b00, quo_q, 2'b01};
    step_bit = 1'b0;
    step_rem = rem_q;
    if (!op_q) begin
      step_bit = (rem_q >= div_cmp);
      step_rem = step_bit ? (rem_q - div_cmp) : rem_q;
      step_rem = {step_rem[RW-2:0], 1'b0};
    end else begin
      step_bit = (rem_sh >= trial);
      step_rem = step_bit ? (rem_sh - trial) : rem_sh;
    end
  end

  // Normalise and round
  logic [QW-1:0]     qn;
  logic signed [9:0] exp_n, exp_f;
  logic [23:0]       mant;
  logic [24:0]       mant_r;
  logic [22:0]       frac_f;
  logic              rbit, sticky, inc, nx;
  logic [31:0]       round_res;
  logic [4:0]        round_flags;

  always_comb begin
    qn     = quo_q[QW-1] ? quo_q : {quo_q[QW-2:0], 1'b0};
    exp_n  = quo_q[QW-1] ? exp_q : exp_q - 10'sd1;
    mant   = qn[QW-1 -: 24];
    rbit   = qn[QW-25];
    sticky = (|(qn & LOW_MASK)) | (|rem_q);
    inc    = rbit & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {24'd0, inc};
    // A carry out of rounding leaves the mantissa at exactly 1.0
    exp_f  = mant_r[24] ? exp_n + 10'sd1 : exp_n;
    frac_f = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    nx     = rbit | sticky;
    if (exp_f >= 10'sd255) begin
      round_res   = {sign_q, 8'hFF, 23'd0};
      round_flags = 5'b00101;
    end else if (exp_f <= 10'sd0) begin
      round_res   = {sign_q, 31'd0};
      round_flags = 5'b00011;
    end else begin
      round_res   = {sign_q, exp_f[7:0], frac_f};
      round_flags = {4'b0000, nx};
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    rad_d    = rad_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    fflags_d = fflags_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d    = OP;
          a_d     = DATA1;
          b_d     = DATA2;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        cnt_d = '0;
        quo_d = '0;
        if (spec_hit) begin
          result_d = spec_res;
          fflags_d = spec_flags;
          state_d  = S_FINISH;
        end else begin
          state_d = S_ITER;
          if (!op_q) begin
            sign_d = s1 ^ s2;
            exp_d  = signed'({2'b00, e1}) - signed'({2'b00, e2}) + 10'sd127;
            rem_d  = {{(RW-24){1'b0}}, m1};
            dvs_d  = m2;
            rad_d  = '0;
          end else begin
            sign_d = 1'b0;
            exp_d  = (ue1 >>> 1) + 10'sd127;
            rem_d  = '0;
            // Odd exponent: radicand shifted one extra place so the exponent halves exactly
            rad_d  = ue1[0] ? ({{(2*QW-24){1'b0}}, m1} << (2*QW-24))
                            : ({{(2*QW-24){1'b0}}, m1} << (2*QW-25));
          end
        end
      end
      S_ITER: begin
        quo_d = {quo_q[QW-2:0], step_bit};
        rem_d = step_rem;
        rad_d = {rad_q[2*QW-3:0], 2'b00};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER_BITS-1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = round_res;
        fflags_d = round_flags;
        state_d  = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      rad_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      rad_q    <= rad_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_FINISH);
  assign RESULT    = result_q;
  assign FFLAGS    = fflags_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_f_div_sqrt_unit.sv
// Directed bench for f_div_sqrt_unit: hand-computed results, flags, latency and handshake behaviour.
module tb_f_div_sqrt_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] data1, data2;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic [2:0]  state_dbg;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  f_div_sqrt_unit dut (
    .CLK(clk), .RESET(reset), .START(start), .OP(op),
    .DATA1(data1), .DATA2(data2),
    .BUSY(busy), .DONE(done), .RESULT(result), .FFLAGS(fflags),
    .STATE_DBG(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle START; returns just after the accepting edge (edge 0)
  task automatic do_start(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Latency = index of the edge at which DONE is first sampled high
  task automatic wait_done(output logic seen, output int lat);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = lat + 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [4:0] exp_flags, input int exp_lat);
    logic seen;
    int   lat;
    do_start(o, a, b);
    wait_done(seen, lat);
    check({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_result"}, result, exp_res);
      check({tag, "_flags"}, 32'(fflags), 32'(exp_flags));
      check({tag, "_busy_on_done"}, 32'(busy), 32'd1);
      if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
      @(negedge clk);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_held"}, result, exp_res);
    end
  endtask

  initial begin
    logic        seen;
    int          lat;
    int          n_done;
    logic [31:0] r;
    logic [4:0]  f;

    reset = 1'b1; start = 1'b0; op = 1'b0; data1 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", result,      32'd0);
    check("rst_flags",  32'(fflags), 32'd0);

    run_op("div_6_2",   1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29);
    run_op("div_1_3",   1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29);
    run_op("div_1_0",   1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2);
    run_op("div_0_0",   1'b0, 32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000, 2);
    run_op("div_neg",   1'b0, 32'hC1200000, 32'h40000000, 32'hC0A00000, 5'b00000, 29);
    run_op("sqrt_4",    1'b1, 32'h40800000, 32'h12345678, 32'h40000000, 5'b00000, 29);
    run_op("sqrt_2",    1'b1, 32'h40000000, 32'h00000000, 32'h3FB504F3, 5'b00001, 29);
    run_op("sqrt_nz",   1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 5'b00000, 2);

    // sqrt(-1) with START held through the DONE cycle: the DONE-cycle START must not be taken
    @(negedge clk);
    op = 1'b1; data1 = 32'hBF800000; data2 = '0; start = 1'b1;
    @(posedge clk);
    wait_done(seen, lat);
    check("sqrt_neg_done",   32'(seen),   32'd1);
    check("sqrt_neg_result", result,      32'h7FC00000);
    check("sqrt_neg_flags",  32'(fflags), 32'b10000);
    check("sqrt_neg_lat",    lat,         2);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("done_cycle_start_ignored", 32'(busy), 32'd0);

    // Overflow with a second START pulsed while busy
    do_start(1'b0, 32'h7F000000, 32'h00800000);
    n_done = 0; r = '0; f = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        r = result;
        f = fflags;
      end
      if (i == 5) begin
        op = 1'b0; data1 = 32'h40C00000; data2 = 32'h40000000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("of_single_done", n_done, 1);
    check("of_result", r, 32'h7F800000);
    check("of_flags",  32'(f), 32'b00101);

    // Reset 10 cycles into a divide
    do_start(1'b0, 32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_done",   32'(done), 32'd0);
    check("abort_result", result,    32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    run_op("div_6_2_again", 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
